// File: rtl/stq_pkg.sv
// Shared constants, pointer type and the occupancy helper for the store-queue
// pointer controller.
package stq_pkg;

    localparam int STQ_ENTRIES = 64;
    localparam int STQ_IDX_W   = 6;
    localparam int STQ_PTR_W   = 7;

    // Pointer = 6 index bits plus a wrap bit in the MSB.
    typedef logic [STQ_PTR_W-1:0] stq_ptr_t;

    // Occupancy between two pointers; the wrap bit makes 64 distinct from 0.
    function automatic stq_ptr_t stq_count(input stq_ptr_t tail, input stq_ptr_t head);
        return stq_ptr_t'(tail - head);
    endfunction

endpackage

// File: rtl/stq_ptr_ctrl_if.sv
// Bundle of the allocate / write / commit / drain signals of stq_ptr_ctrl.
// The master side is the surrounding pipeline and array; the slave side is
// the controller. The hwm port exists only when STQ_PTR_CTRL_STATS_EN is defined.
interface stq_ptr_ctrl_if
    import stq_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic [1:0]             alloc_cnt;
    logic                   alloc_ok;
    stq_ptr_t               alloc_id0;
    stq_ptr_t               alloc_id1;
    logic                   wr0_vld;
    logic [STQ_IDX_W-1:0]   wr0_id;
    logic                   wr1_vld;
    logic [STQ_IDX_W-1:0]   wr1_id;
    logic [STQ_ENTRIES-1:0] wrt0_en;
    logic [STQ_ENTRIES-1:0] wrt1_en;
    logic [1:0]             commit_cnt;
    logic                   flush;
    logic [STQ_ENTRIES-1:0] drain_en;
    logic [WIDTH-1:0]       drain_data_in;
    logic                   drain_valid;
    logic [STQ_IDX_W-1:0]   drain_id;
    logic [WIDTH-1:0]       drain_data;
    logic                   drain_ready;
    logic                   full;
    logic                   empty;
`ifdef STQ_PTR_CTRL_STATS_EN
    stq_ptr_t               hwm;
`endif

    modport master (
        output alloc_cnt, wr0_vld, wr0_id, wr1_vld, wr1_id, commit_cnt, flush,
               drain_data_in, drain_ready,
        input  alloc_ok, alloc_id0, alloc_id1, wrt0_en, wrt1_en, drain_en,
               drain_valid, drain_id, drain_data, full, empty
`ifdef STQ_PTR_CTRL_STATS_EN
        , input hwm
`endif
    );

    modport slave (
        input  alloc_cnt, wr0_vld, wr0_id, wr1_vld, wr1_id, commit_cnt, flush,
               drain_data_in, drain_ready,
        output alloc_ok, alloc_id0, alloc_id1, wrt0_en, wrt1_en, drain_en,
               drain_valid, drain_id, drain_data, full, empty
`ifdef STQ_PTR_CTRL_STATS_EN
        , output hwm
`endif
    );

endinterface

// File: rtl/stq_onehot_dec.sv
// 6-bit index to 64-bit one-hot decoder with an enable; all zeros when disabled.
module stq_onehot_dec
    import stq_pkg::*;
(
    input  logic [STQ_IDX_W-1:0]   idx,
    input  logic                   en,
    output logic [STQ_ENTRIES-1:0] onehot
);

    genvar gi;
    generate
        for (gi = 0; gi < STQ_ENTRIES; gi++) begin : g_bit
            assign onehot[gi] = en && (idx == STQ_IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/stq_ptr_ctrl.sv
// Store-queue pointer and handshake controller.
// Keeps head / commit / tail pointers (with wrap bit) and per-entry data-ready
// bits, grants allocations, turns execute writes into one-hot array enables and
// drains committed, data-ready entries in order through a valid/ready port.
// Optional: define STQ_PTR_CTRL_STATS_EN to add the hwm high-water-mark output.
module stq_ptr_ctrl
    import stq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int ENTRIES = STQ_ENTRIES
)
(
    input  logic          clk,
    input  logic          rst,
    stq_ptr_ctrl_if.slave bus
);

    stq_ptr_t               head_reg, head_next;
    stq_ptr_t               cmt_reg, cmt_next;
    stq_ptr_t               tail_reg, tail_next;
    stq_ptr_t               count;
    stq_ptr_t               cmt_room;
    stq_ptr_t               cmt_inc;
    stq_ptr_t               sq_cnt;
    logic [7:0]             alloc_total;
    logic                   alloc_ok;
    logic                   head_ne_cmt;
    logic                   drain_valid;
    logic                   drain_fire;
    logic [ENTRIES-1:0]     data_rdy_reg, data_rdy_next;
    logic [ENTRIES-1:0]     sq_clr;
    logic [ENTRIES-1:0]     wrt0_en, wrt1_en, drain_en;
    logic [WIDTH-1:0]       drain_word;

    // Occupancy and the all-or-nothing allocation grant; flush always refuses.
    assign count       = stq_count(tail_reg, head_reg);
    assign alloc_total = {1'b0, count} + {6'b0, bus.alloc_cnt};
    assign alloc_ok    = (alloc_total <= 8'd64) && !bus.flush;

    // Commit can never pass the tail; an oversized commit_cnt is clamped.
    assign cmt_room = stq_ptr_t'(tail_reg - cmt_reg);
    assign cmt_inc  = ({5'b0, bus.commit_cnt} > cmt_room) ? cmt_room : {5'b0, bus.commit_cnt};
    assign cmt_next = stq_ptr_t'(cmt_reg + cmt_inc);

    // Flush rewinds the tail to the already-advanced commit pointer.
    assign tail_next = bus.flush ? cmt_next
                     : alloc_ok  ? stq_ptr_t'(tail_reg + {5'b0, bus.alloc_cnt})
                     : tail_reg;

    // Head entry is offered once committed and written; it leaves on handshake.
    assign head_ne_cmt = (head_reg != cmt_reg);
    assign drain_valid = head_ne_cmt && data_rdy_reg[head_reg[STQ_IDX_W-1:0]];
    assign drain_fire  = drain_valid && bus.drain_ready;
    assign head_next   = stq_ptr_t'(head_reg + {6'b0, drain_fire});

    // Number of entries squashed by a flush, counted from the new commit point.
    assign sq_cnt = stq_ptr_t'(tail_reg - cmt_next);

    stq_onehot_dec u_dec_wrt0 (.idx(bus.wr0_id),                  .en(bus.wr0_vld),  .onehot(wrt0_en));
    stq_onehot_dec u_dec_wrt1 (.idx(bus.wr1_id),                  .en(bus.wr1_vld),  .onehot(wrt1_en));
    stq_onehot_dec u_dec_drn  (.idx(head_reg[STQ_IDX_W-1:0]),     .en(head_ne_cmt),  .onehot(drain_en));

    // Per-entry ready bit: set by a write, cleared by drain or by being squashed.
    // The squash test uses the index distance from the new commit point so it
    // works across the wrap; squash beats a same-cycle write to that entry.
    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_rdy
            logic [STQ_IDX_W-1:0] ofs;
            assign ofs           = STQ_IDX_W'(STQ_IDX_W'(gi) - cmt_next[STQ_IDX_W-1:0]);
            assign sq_clr[gi]    = bus.flush && ({1'b0, ofs} < sq_cnt);
            assign data_rdy_next[gi] = (data_rdy_reg[gi] | wrt0_en[gi] | wrt1_en[gi])
                                     & ~sq_clr[gi]
                                     & ~(drain_en[gi] & drain_fire);
        end
    endgenerate

    // Pointer and ready-bit state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg     <= '0;
            cmt_reg      <= '0;
            tail_reg     <= '0;
            data_rdy_reg <= '0;
        end else begin
            head_reg     <= head_next;
            cmt_reg      <= cmt_next;
            tail_reg     <= tail_next;
            data_rdy_reg <= data_rdy_next;
        end
    end

`ifdef STQ_PTR_CTRL_STATS_EN
    stq_ptr_t hwm_reg;

    // High-water mark of occupancy; flush does not lower it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hwm_reg <= '0;
        end else if (count > hwm_reg) begin
            hwm_reg <= count;
        end
    end

    assign bus.hwm = hwm_reg;
`endif

    assign drain_word     = bus.drain_data_in;

    assign bus.alloc_ok    = alloc_ok;
    assign bus.alloc_id0   = tail_reg;
    assign bus.alloc_id1   = stq_ptr_t'(tail_reg + 7'd1);
    assign bus.wrt0_en     = wrt0_en;
    assign bus.wrt1_en     = wrt1_en;
    assign bus.drain_en    = drain_en;
    assign bus.drain_valid = drain_valid;
    assign bus.drain_id    = head_reg[STQ_IDX_W-1:0];
    assign bus.drain_data  = drain_word;
    assign bus.full        = (count == 7'd64);
    assign bus.empty       = (count == 7'd0);

    // Retiring more stores than are outstanding is an upstream protocol error.
    commit_in_range: assert property (@(posedge clk) disable iff (rst)
        ({5'b0, bus.commit_cnt} <= cmt_room));

endmodule

// File: tb/tb_stq_ptr_ctrl.sv
// Bench for stq_ptr_ctrl: vector table for allocation up to full, hand
// sequences for drain stall, flush, wrap, same-ID writes and async reset.
// Drained entries are checked against a queue of committed IDs.
module tb_stq_ptr_ctrl;

    logic clk;
    logic rst;

    stq_ptr_ctrl_if #(.WIDTH(32)) bus ();

    stq_ptr_ctrl #(.WIDTH(32), .ENTRIES(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int drain_cnt = 0;
    int b_cmt = 0;

    logic [31:0] exp_data [64];
    logic [31:0] mem [64];
    logic [31:0] wr0_data, wr1_data;
    logic [5:0]  sb [$];

    typedef struct {
        logic [1:0] alloc_cnt;
        logic       ok;
        logic [6:0] id0;
        logic [6:0] id1;
        logic       full;
        logic       empty;
    } vec_t;

    vec_t vt [34];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Array model: port 1 is written after port 0 so it wins on a collision.
    always @(posedge clk) begin
        for (int i = 0; i < 64; i++) begin
            if (bus.wrt0_en[i]) mem[i] <= wr0_data;
            if (bus.wrt1_en[i]) mem[i] <= wr1_data;
        end
    end

    always_comb begin
        bus.drain_data_in = '0;
        for (int i = 0; i < 64; i++)
            if (bus.drain_en[i]) bus.drain_data_in = mem[i];
    end

    // Drain monitor: each handshake pops the oldest committed ID.
    always @(negedge clk) begin
        logic [5:0] eid;
        if (!rst && bus.drain_valid && bus.drain_ready) begin
            if (sb.size() == 0) begin
                chk("drain_unexpected", {58'd0, bus.drain_id}, 64'hffff);
            end else begin
                eid = sb.pop_front();
                chk("drain_id", {58'd0, bus.drain_id}, {58'd0, eid});
                chk("drain_data", {32'd0, bus.drain_data}, {32'd0, exp_data[eid]});
            end
            drain_cnt++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        bus.alloc_cnt  = 2'd0;
        bus.wr0_vld    = 1'b0;
        bus.wr1_vld    = 1'b0;
        bus.commit_cnt = 2'd0;
        bus.flush      = 1'b0;
    endtask

    task automatic wr(input int port, input int id, input logic [31:0] d);
        if (port == 0) begin
            bus.wr0_vld = 1'b1; bus.wr0_id = 6'(id); wr0_data = d;
        end else begin
            bus.wr1_vld = 1'b1; bus.wr1_id = 6'(id); wr1_data = d;
        end
        exp_data[id] = d;
    endtask

    task automatic commit(input int n);
        bus.commit_cnt = 2'(n);
        for (int k = 0; k < n; k++) begin
            sb.push_back(6'(b_cmt % 64));
            b_cmt++;
        end
    endtask

    task automatic wait_drains(input string nm, input int target, input int budget);
        int n = 0;
        while (drain_cnt < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(nm, 64'(drain_cnt >= target), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] bit5;
        logic [31:0] da, db;
        int base;

        bit5 = 64'd1 << 5;
        for (int i = 0; i < 32; i++)
            vt[i] = '{alloc_cnt: 2'd2, ok: 1'b1, id0: 7'(2 * i), id1: 7'(2 * i + 1),
                      full: 1'b0, empty: (i == 0)};
        vt[32] = '{alloc_cnt: 2'd1, ok: 1'b0, id0: 7'd64, id1: 7'd65, full: 1'b1, empty: 1'b0};
        vt[33] = '{alloc_cnt: 2'd0, ok: 1'b1, id0: 7'd64, id1: 7'd65, full: 1'b1, empty: 1'b0};

        rst = 1'b1;
        bus.alloc_cnt = 0; bus.wr0_vld = 0; bus.wr0_id = 0; bus.wr1_vld = 0; bus.wr1_id = 0;
        bus.commit_cnt = 0; bus.flush = 0; bus.drain_ready = 0;
        wr0_data = 0; wr1_data = 0;
        for (int i = 0; i < 64; i++) exp_data[i] = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_full", 64'(bus.full), 64'd0);
        chk("rst_empty", 64'(bus.empty), 64'd1);
        chk("rst_drain_valid", 64'(bus.drain_valid), 64'd0);
        chk("rst_alloc_ok", 64'(bus.alloc_ok), 64'd1);
        chk("rst_wrt0_en", bus.wrt0_en, 64'd0);
        chk("rst_wrt1_en", bus.wrt1_en, 64'd0);
        chk("rst_drain_en", bus.drain_en, 64'd0);
`ifdef STQ_PTR_CTRL_STATS_EN
        chk("rst_hwm", 64'(bus.hwm), 64'd0);
`endif
        cyc();

        // 1: fill to 64 through the vector table
        for (int i = 0; i < 34; i++) begin
            bus.alloc_cnt = vt[i].alloc_cnt;
            @(negedge clk);
            $display("vec %0d alloc_cnt=%0d ok=%0b id0=%0d full=%0b", i, vt[i].alloc_cnt,
                     bus.alloc_ok, bus.alloc_id0, bus.full);
            chk("t1_alloc_ok", 64'(bus.alloc_ok), 64'(vt[i].ok));
            chk("t1_id0", 64'(bus.alloc_id0), 64'(vt[i].id0));
            chk("t1_id1", 64'(bus.alloc_id1), 64'(vt[i].id1));
            chk("t1_full", 64'(bus.full), 64'(vt[i].full));
            chk("t1_empty", 64'(bus.empty), 64'(vt[i].empty));
            cyc();
        end

        // Flush everything (nothing committed); alloc loses to flush
        bus.alloc_cnt = 2'd1; bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_alloc_ok", 64'(bus.alloc_ok), 64'd0);
        cyc();
        @(negedge clk);
        chk("flush_empty", 64'(bus.empty), 64'd1);
        chk("flush_full", 64'(bus.full), 64'd0);
        chk("flush_tail", 64'(bus.alloc_id0), 64'd0);
        cyc();

        // 2: in-order drain stalls on an unwritten entry
        bus.alloc_cnt = 2'd2; cyc();
        bus.alloc_cnt = 2'd1; cyc();
        wr(0, 2, $urandom); wr(1, 0, $urandom);
        @(negedge clk);
        chk("t2_wrt0_en", bus.wrt0_en, 64'd1 << 2);
        chk("t2_wrt1_en", bus.wrt1_en, 64'd1);
        cyc();
        bus.drain_ready = 1'b1;
        commit(2);
        @(negedge clk);
        chk("t2_pre_valid", 64'(bus.drain_valid), 64'd0);
        chk("t2_pre_drain_en", bus.drain_en, 64'd0);
        cyc();
        commit(1);
        @(negedge clk);
        chk("t2_id0_valid", 64'(bus.drain_valid), 64'd1);
        cyc();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t2_stall_valid", 64'(bus.drain_valid), 64'd0);
            chk("t2_stall_id", 64'(bus.drain_id), 64'd1);
            chk("t2_stall_en", bus.drain_en, 64'd2);
            cyc();
        end
        wr(0, 1, $urandom);
        @(negedge clk);
        chk("t2_wr1_valid", 64'(bus.drain_valid), 64'd0);
        cyc();
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            chk("t2_seq_valid", 64'(bus.drain_valid), 64'd1);
            chk("t2_seq_id", 64'(bus.drain_id), 64'(k));
            cyc();
        end
        @(negedge clk);
        chk("t2_empty", 64'(bus.empty), 64'd1);
        chk("t2_drain_valid", 64'(bus.drain_valid), 64'd0);
        cyc();

        // 3: flush squashes uncommitted entries; pointers at 3
        bus.drain_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.alloc_cnt = 2'd2;
            @(negedge clk);
            chk("t3_alloc_id0", 64'(bus.alloc_id0), 64'(3 + 2 * k));
            cyc();
        end
        for (int k = 0; k < 5; k++) begin
            wr(0, 3 + 2 * k, $urandom); wr(1, 4 + 2 * k, $urandom); cyc();
        end
        commit(2); cyc();
        commit(2); cyc();
        commit(2); bus.flush = 1'b1; bus.alloc_cnt = 2'd2; wr(0, 10, $urandom);
        @(negedge clk);
        chk("t3_flush_alloc_ok", 64'(bus.alloc_ok), 64'd0);
        chk("t3_flush_wrt0", bus.wrt0_en, 64'd1 << 10);
        cyc();
        bus.alloc_cnt = 2'd2;
        @(negedge clk);
        chk("t3_post_id0", 64'(bus.alloc_id0), 64'd9);
        chk("t3_post_ok", 64'(bus.alloc_ok), 64'd1);
        cyc();
        bus.alloc_cnt = 2'd2;
        @(negedge clk);
        chk("t3_post_id0b", 64'(bus.alloc_id0), 64'd11);
        cyc();
        commit(2); cyc();
        commit(2); cyc();
        base = drain_cnt;
        bus.drain_ready = 1'b1;
        wait_drains("t3_drain6", base + 6, 20);
        @(negedge clk);
        chk("t3_rdy9_clear", 64'(bus.drain_valid), 64'd0);
        chk("t3_head9", 64'(bus.drain_id), 64'd9);
        cyc();
        wr(0, 9, $urandom); cyc();
        wait_drains("t3_drain9", base + 7, 10);
        @(negedge clk);
        chk("t3_rdy10_clear", 64'(bus.drain_valid), 64'd0);
        chk("t3_head10", 64'(bus.drain_id), 64'd10);
        cyc();
        wr(0, 10, $urandom); wr(1, 11, $urandom); cyc();
        wr(0, 12, $urandom); cyc();
        wait_drains("t3_drain_rest", base + 10, 10);
        @(negedge clk);
        chk("t3_empty", 64'(bus.empty), 64'd1);
        cyc();

        // 4: advance to 62, then allocate across the wrap
        for (int k = 0; k < 24; k++) begin bus.alloc_cnt = 2'd2; cyc(); end
        bus.alloc_cnt = 2'd1; cyc();
        for (int id = 13; id < 62; id += 2) begin
            wr(0, id, $urandom);
            if (id + 1 < 62) wr(1, id + 1, $urandom);
            cyc();
        end
        base = drain_cnt;
        for (int k = 0; k < 24; k++) begin commit(2); cyc(); end
        commit(1); cyc();
        wait_drains("t4_drain49", base + 49, 80);
        @(negedge clk);
        chk("t4_empty62", 64'(bus.empty), 64'd1);
        chk("t4_head62", 64'(bus.drain_id), 64'd62);
        cyc();
        bus.alloc_cnt = 2'd2;
        @(negedge clk);
        chk("t4_id0_62", 64'(bus.alloc_id0), 64'd62);
        chk("t4_id1_63", 64'(bus.alloc_id1), 64'd63);
        cyc();
        bus.alloc_cnt = 2'd2;
        @(negedge clk);
        chk("t4_id0_64", 64'(bus.alloc_id0), 64'd64);
        chk("t4_id1_65", 64'(bus.alloc_id1), 64'd65);
        chk("t4_ok", 64'(bus.alloc_ok), 64'd1);
        cyc();
        wr(0, 62, $urandom); wr(1, 63, $urandom); cyc();
        wr(0, 0, $urandom); wr(1, 1, $urandom); cyc();
        base = drain_cnt;
        commit(2); cyc();
        commit(2); cyc();
        wait_drains("t4_drain_wrap", base + 4, 10);
        @(negedge clk);
        chk("t4_empty", 64'(bus.empty), 64'd1);
        chk("t4_valid", 64'(bus.drain_valid), 64'd0);
        chk("t4_head2", 64'(bus.drain_id), 64'd2);
        cyc();

        // 5: both write ports hit index 5; port 1 data must be drained
        bus.alloc_cnt = 2'd2; cyc();
        bus.alloc_cnt = 2'd2; cyc();
        wr(0, 2, $urandom); wr(1, 3, $urandom); cyc();
        wr(0, 4, $urandom); cyc();
        da = 32'hA5A5_0000 | 32'($urandom_range(0, 65535));
        db = ~da;
        wr(0, 5, da); wr(1, 5, db);
        @(negedge clk);
        chk("t5_wrt0_en", bus.wrt0_en, bit5);
        chk("t5_wrt1_en", bus.wrt1_en, bit5);
        cyc();
        base = drain_cnt;
        commit(2); cyc();
        commit(2); cyc();
        wait_drains("t5_drain4", base + 4, 10);
        chk("t5_mem5_wr1", {32'd0, mem[5]}, {32'd0, db});
        chk("t5_sb_empty", 64'(sb.size()), 64'd0);

        // 6: asynchronous reset while an entry is being offered
        bus.drain_ready = 1'b0;
        bus.alloc_cnt = 2'd1; cyc();
        wr(0, 6, $urandom); cyc();
        commit(1); cyc();
        @(negedge clk);
        chk("t6_valid_pre", 64'(bus.drain_valid), 64'd1);
        chk("t6_id_pre", 64'(bus.drain_id), 64'd6);
`ifdef STQ_PTR_CTRL_STATS_EN
        chk("t6_hwm_pre", 64'(bus.hwm), 64'd64);
`endif
        #2 rst = 1'b1;
        #1;
        chk("t6_valid_rst", 64'(bus.drain_valid), 64'd0);
        chk("t6_empty_rst", 64'(bus.empty), 64'd1);
        chk("t6_full_rst", 64'(bus.full), 64'd0);
        chk("t6_alloc_ok_rst", 64'(bus.alloc_ok), 64'd1);
        chk("t6_drain_en_rst", bus.drain_en, 64'd0);
`ifdef STQ_PTR_CTRL_STATS_EN
        chk("t6_hwm_rst", 64'(bus.hwm), 64'd0);
`endif
        sb.delete();
        b_cmt = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_id0_after", 64'(bus.alloc_id0), 64'd0);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
